// File: rtl/decoder_seq_pkg.sv
// Shared types and constants for the decoder_seq one-hot decoder / sweep sequencer.
package decoder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

endpackage

// File: rtl/decoder_onehot.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable; shared by the direct and sweep paths.
module decoder_onehot #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [2**SEL_W-1:0]   onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < 2**SEL_W; gi++) begin : g_line
      assign onehot[gi] = en && (sel == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with a sequential sweep mode (IDLE/SWEEP/DONE).
// Build option: DECODER_SEQ_INV_OUT_EN makes out active-low (inactive = all ones).
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int HOLD  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  start,
  output logic [2**SEL_W-1:0]   out,
  output logic                  busy,
  output logic                  done
);

  localparam int OUT_W   = 2**SEL_W;
  localparam int DWELL_W = $clog2(HOLD + 1);
  localparam int STEP_W  = SEL_W + 1;

`ifdef DECODER_SEQ_INV_OUT_EN
  localparam logic [OUT_W-1:0] OUT_POL = '1;
`else
  localparam logic [OUT_W-1:0] OUT_POL = '0;
`endif

  state_t               state_reg, state_next;
  logic [SEL_W-1:0]     index_reg, index_next;
  logic [DWELL_W-1:0]   dwell_reg, dwell_next;
  logic [STEP_W-1:0]    step_reg, step_next;
  logic                 shown_reg, shown_next;
  logic [OUT_W-1:0]     out_reg;

  logic [SEL_W-1:0]     dec_sel;
  logic                 dec_en;
  logic [OUT_W-1:0]     dec_onehot;

  decoder_onehot #(.SEL_W(SEL_W)) u_onehot (
    .sel    (dec_sel),
    .en     (dec_en),
    .onehot (dec_onehot)
  );

  // shown_reg marks that the cycle now ending displayed the current line,
  // so dwell only advances for cycles the line was actually visible.
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    dwell_next = dwell_reg;
    step_next  = step_reg;
    shown_next = shown_reg;
    dec_sel    = sel;
    dec_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        dec_sel = sel;
        dec_en  = en;
        if (start && en && (mode == MODE_SWEEP)) begin
          state_next = SWEEP;
          index_next = sel;
          dwell_next = '0;
          step_next  = '0;
          shown_next = 1'b1;
        end
      end
      SWEEP: begin
        dec_sel    = index_reg;
        dec_en     = en;
        shown_next = en;
        if (shown_reg) begin
          if (dwell_reg == DWELL_W'(HOLD - 1)) begin
            dwell_next = '0;
            if (step_reg == STEP_W'(OUT_W - 1)) begin
              state_next = DONE;
              dec_en     = 1'b0;
            end else begin
              index_next = index_reg + 1'b1;
              step_next  = step_reg + 1'b1;
              dec_sel    = index_reg + 1'b1;
            end
          end else begin
            dwell_next = dwell_reg + 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        dec_en     = 1'b0;
      end
      default: begin
        state_next = IDLE;
        dec_en     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      index_reg <= '0;
      dwell_reg <= '0;
      step_reg  <= '0;
      shown_reg <= 1'b0;
      out_reg   <= OUT_POL;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      dwell_reg <= dwell_next;
      step_reg  <= step_next;
      shown_reg <= shown_next;
      out_reg   <= dec_onehot ^ OUT_POL;
    end
  end

  assign out  = out_reg;
  assign busy = (state_reg == SWEEP);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq (SEL_W=3, HOLD=2): direct decode, sweeps with wrap, pause and abort.
module tb_decoder_seq;
  import decoder_seq_pkg::*;

  localparam int SEL_W = 3;
  localparam int HOLD  = 2;
  localparam int OUT_W = 8;

`ifdef DECODER_SEQ_INV_OUT_EN
  localparam logic [OUT_W-1:0] INV = '1;
`else
  localparam logic [OUT_W-1:0] INV = '0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [SEL_W-1:0] sel = '0;
  logic             mode = MODE_DIRECT;
  logic             start = 1'b0;
  logic [OUT_W-1:0] out;
  logic             busy;
  logic             done;

  decoder_seq #(.SEL_W(SEL_W), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .sel   (sel),
    .mode  (mode),
    .start (start),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [OUT_W-1:0] out;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] line_vec(input int line);
    logic [OUT_W-1:0] v;
    v = (line < 0) ? '0 : (OUT_W'(1) << line);
    return v ^ INV;
  endfunction

  // Monitor: one expected entry is consumed per clock, just after the edge.
  always begin
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      $display("[%0t] %s out=%b busy=%b done=%b", $time, mon_e.tag, out, busy, done);
      chk({mon_e.tag, ".out"},  32'(out),  32'(mon_e.out));
      chk({mon_e.tag, ".busy"}, 32'(busy), 32'(mon_e.busy));
      chk({mon_e.tag, ".done"}, 32'(done), 32'(mon_e.done));
    end
  end

  // Drive one cycle of inputs and queue what the DUT must show after the next edge.
  task automatic cyc(input logic e, input logic [SEL_W-1:0] s, input logic m, input logic st,
                     input int line, input logic b, input logic d, input string tag);
    exp_t x;
    en = e; sel = s; mode = m; start = st;
    x.tag = tag; x.out = line_vec(line); x.busy = b; x.done = d;
    sb_q.push_back(x);
    @(negedge clk);
  endtask

  function automatic logic [SEL_W-1:0] rnd_sel();
    return SEL_W'($urandom_range(0, OUT_W - 1));
  endfunction

  // Full sweep from s0 with noisy sel/mode and a stray start mid-sweep.
  task automatic sweep_run(input int s0);
    cyc(1'b1, SEL_W'(s0), MODE_SWEEP, 1'b1, s0, 1'b1, 1'b0, "launch");
    for (int k = 0; k < OUT_W; k++) begin
      for (int h = 0; h < HOLD; h++) begin
        if (k == 0 && h == 0) continue;
        cyc(1'b1, rnd_sel(), 1'($urandom_range(0, 1)), (k == 3 && h == 0),
            (s0 + k) % OUT_W, 1'b1, 1'b0, "sweep");
      end
    end
    cyc(1'b1, rnd_sel(), MODE_SWEEP, 1'b1, -1, 1'b0, 1'b1, "done");
    cyc(1'b0, '0, MODE_DIRECT, 1'b0, -1, 1'b0, 1'b0, "after_done");
  endtask

  initial begin
    #12;
    chk("reset.out",  32'(out),  32'(INV));
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Direct decode, enable gating, ignored starts
    cyc(1'b1, 3'd2, MODE_DIRECT, 1'b0, 2,  1'b0, 1'b0, "direct2");
    cyc(1'b1, 3'd5, MODE_DIRECT, 1'b0, 5,  1'b0, 1'b0, "direct5");
    cyc(1'b0, 3'd5, MODE_DIRECT, 1'b0, -1, 1'b0, 1'b0, "en_low");
    cyc(1'b1, 3'd6, MODE_DIRECT, 1'b1, 6,  1'b0, 1'b0, "start_mode0");
    cyc(1'b0, 3'd3, MODE_SWEEP,  1'b1, -1, 1'b0, 1'b0, "start_en0");
    cyc(1'b1, 3'd1, MODE_DIRECT, 1'b0, 1,  1'b0, 1'b0, "direct1");
    cyc(1'b1, 3'd7, MODE_DIRECT, 1'b0, 7,  1'b0, 1'b0, "direct7");
    cyc(1'b1, 3'd0, MODE_DIRECT, 1'b0, 0,  1'b0, 1'b0, "direct0");

    // Sweep that wraps 7 -> 0
    sweep_run(6);
    cyc(1'b1, 3'd4, MODE_DIRECT, 1'b0, 4, 1'b0, 1'b0, "direct4");

    // Pause mid-dwell of line 1
    cyc(1'b1, 3'd0, MODE_SWEEP, 1'b1, 0, 1'b1, 1'b0, "p_launch");
    cyc(1'b1, rnd_sel(), MODE_SWEEP, 1'b0, 0, 1'b1, 1'b0, "p_line0");
    cyc(1'b1, rnd_sel(), MODE_SWEEP, 1'b0, 1, 1'b1, 1'b0, "p_line1");
    for (int i = 0; i < 5; i++)
      cyc(1'b0, rnd_sel(), MODE_SWEEP, 1'b1, -1, 1'b1, 1'b0, "pause");
    cyc(1'b1, rnd_sel(), MODE_DIRECT, 1'b0, 1, 1'b1, 1'b0, "p_resume1");
    for (int k = 2; k < OUT_W; k++)
      for (int h = 0; h < HOLD; h++)
        cyc(1'b1, rnd_sel(), MODE_DIRECT, 1'b0, k, 1'b1, 1'b0, "p_sweep");
    cyc(1'b0, '0, MODE_DIRECT, 1'b0, -1, 1'b0, 1'b1, "p_done");
    cyc(1'b0, '0, MODE_DIRECT, 1'b0, -1, 1'b0, 1'b0, "p_idle");

    // Asynchronous abort mid-sweep
    cyc(1'b1, 3'd4, MODE_SWEEP, 1'b1, 4, 1'b1, 1'b0, "a_launch");
    cyc(1'b1, 3'd0, MODE_DIRECT, 1'b0, 4, 1'b1, 1'b0, "a_line4");
    cyc(1'b1, 3'd0, MODE_DIRECT, 1'b0, 5, 1'b1, 1'b0, "a_line5");
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.out",  32'(out),  32'(INV));
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    @(negedge clk);
    cyc(1'b1, 3'd2, MODE_SWEEP, 1'b1, -1, 1'b0, 1'b0, "in_reset");
    cyc(1'b1, 3'd2, MODE_SWEEP, 1'b1, -1, 1'b0, 1'b0, "in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++)
      cyc(1'b0, rnd_sel(), MODE_DIRECT, 1'b0, -1, 1'b0, 1'b0, "post_abort");
    cyc(1'b1, 3'd3, MODE_DIRECT, 1'b0, 3, 1'b0, 1'b0, "direct3");

    // Second sweep from an arbitrary start index
    sweep_run(3);

    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
